// File: rtl/dm_subword.sv
// Sub-word data-memory access unit: byte/halfword stores by read-modify-write
// against a word-only synchronous-read memory, and lane extract/extend on loads.
module dm_subword (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [29:0] mem_addr,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
  output logic        mem_we,
  output logic [31:0] mem_wdata
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        sext_q, sext_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;

  logic        misaligned;
  logic [31:0] shifted;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic [31:0] load_val;
  logic [31:0] merged;

  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_HALF: misaligned = req_addr[0];
      SZ_WORD: misaligned = |req_addr[1:0];
      2'd3:    misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  // Load lane extraction from the word returned in WAIT.
  assign shifted = mem_rdata >> {addr_q[1:0], 3'b000};
  assign lane8   = shifted[7:0];
  assign lane16  = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

  always_comb begin
    load_val = mem_rdata;
    case (size_q)
      SZ_BYTE: load_val = sext_q ? {{24{lane8[7]}}, lane8} : {24'b0, lane8};
      SZ_HALF: load_val = sext_q ? {{16{lane16[15]}}, lane16} : {16'b0, lane16};
      default: load_val = mem_rdata;
    endcase
  end

  // Store merge: each byte lane takes new data only if it is targeted.
  // Only byte and halfword stores ever pass through WAIT.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic       hit;
      logic [7:0] src;
      assign hit = (size_q == SZ_BYTE) ? (addr_q[1:0] == 2'(gi))
                                       : (addr_q[1] == 1'(gi / 2));
      assign src = ((size_q == SZ_HALF) && ((gi % 2) == 1)) ? wdata_q[15:8]
                                                            : wdata_q[7:0];
      assign merged[8*gi +: 8] = hit ? src : mem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    sext_d  = sext_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    merge_d = merge_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          sext_d  = req_sext;
          we_d    = req_we;
          wdata_d = req_wdata;
          err_d   = misaligned;
          if (misaligned)                         state_d = S_RESP;
          else if (req_we && req_size == SZ_WORD) state_d = S_WR;
          else                                    state_d = S_RD;
        end
      end
      S_RD:   state_d = S_WAIT;
      S_WAIT: begin
        if (we_q) begin
          merge_d = merged;
          state_d = S_WR;
        end else begin
          rdata_d = load_val;
          state_d = S_RESP;
        end
      end
      S_WR:   state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_RESP);
  assign err       = (state_q == S_RESP) && err_q;
  assign rdata     = rdata_q;
  assign mem_addr  = addr_q[31:2];
  assign mem_re    = (state_q == S_RD);
  assign mem_we    = (state_q == S_WR);
  assign mem_wdata = (state_q != S_WR) ? 32'd0
                   : (size_q == SZ_WORD) ? wdata_q : merge_q;

endmodule
